// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, state type and helpers for digit_serial_adder
// Purpose: state encoding and counter-width helper shared by the adder files.
// Ports: none (package).
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Digit counter width: clog2(ndig), never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_rca.sv
// rtl/digit_rca.sv - DIGIT-bit ripple-carry adder slice
// Purpose: combinational ripple chain of full-adder cells for one digit.
// Ports:
//   x, y  [DIGIT] digit operands
//   ci           carry in
//   s     [DIGIT] digit sum
//   co           carry out of the top bit
//   c_msb        carry into the top bit (for signed overflow)
module digit_rca #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co    = c[DIGIT];
    c_msb = c[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle adder processing DIGIT bits per clock
// Purpose: adds a + b + cin over NDIG = WIDTH/DIGIT cycles with a start/busy/done handshake.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, sampled only in IDLE
//   a, b [WIDTH]   operands, captured on the accepted start edge
//   cin            carry in, captured with the operands
//   busy           high while digits are processed
//   done           one-cycle completion pulse
//   sum [WIDTH]    result, held until the next completion
//   cout, ovf      carry out and overflow (unsigned carry or signed overflow per SIGNED)
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_shift;

  digit_rca #(.DIGIT(DIGIT)) u_rca (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB end; after NDIG digits the LSB digit has
  // been pushed down to bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_shift = dig_s;
    end else begin : g_multi
      assign res_shift = {dig_s, res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = res_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_co;
        count_d = count_q + CW'(1);
        if (count_q == LAST_DIG) begin
          state_d = S_DONE;
          count_d = '0;
          sum_d   = res_shift;
          cout_d  = dig_co;
          // Final digit's top-bit carry-in is the carry into bit WIDTH-1.
          ovf_d   = (SIGNED != 0) ? (dig_co ^ dig_cmsb) : dig_co;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder
module tb_digit_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;

  logic [3:0]  busy_w;
  logic [3:0]  done_w;
  logic [3:0]  cout_w;
  logic [3:0]  ovf_w;
  logic [15:0] sum_w [4];

  int checks = 0;
  int errors = 0;

  // Configurations: 0 = DIGIT 4 unsigned, 1 = DIGIT 4 signed,
  // 2 = DIGIT 1 unsigned, 3 = DIGIT 16 unsigned.
  int ndig [4] = '{4, 4, 16, 1};
  int sgn  [4] = '{0, 1, 0, 0};

  logic [15:0] prev_sum  [4];
  logic        prev_cout [4];
  logic        prev_ovf  [4];

  digit_serial_adder #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );
  digit_serial_adder #(.WIDTH(16), .DIGIT(4), .SIGNED(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );
  digit_serial_adder #(.WIDTH(16), .DIGIT(1), .SIGNED(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );
  digit_serial_adder #(.WIDTH(16), .DIGIT(16), .SIGNED(0)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy_w[3]), .done(done_w[3]), .sum(sum_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input int is_signed,
                       output logic [15:0] es, output logic ec, output logic eo);
    logic [16:0] full;
    int          sa;
    full = {1'b0, ta} + {1'b0, tb} + 17'(tc);
    sa   = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    es   = full[15:0];
    ec   = full[16];
    eo   = (is_signed != 0) ? ((sa > 32767) || (sa < -32768)) : full[16];
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s busy d%0d", tag, d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("%s done d%0d", tag, d), 32'(done_w[d]), 32'd0);
      chk($sformatf("%s sum d%0d",  tag, d), 32'(sum_w[d]),  32'd0);
      chk($sformatf("%s cout d%0d", tag, d), 32'(cout_w[d]), 32'd0);
      chk($sformatf("%s ovf d%0d",  tag, d), 32'(ovf_w[d]),  32'd0);
    end
  endtask

  // Called at a negedge. Sample k is taken after start edge E0 + k edges.
  // protect=1 re-pulses start (a=AAAA) into E1 and E2, hitting RUN for
  // multi-digit configurations and DONE for the single-digit one.
  task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input bit protect);
    logic [15:0] es [4];
    logic        ec [4];
    logic        eo [4];
    for (int d = 0; d < 4; d++) model(ta, tb, tc, sgn[d], es[d], ec[d], eo[d]);
    a = ta; b = tb; cin = tc; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("%s busy d%0d k%0d", tag, d, k), 32'(busy_w[d]), 32'(k < ndig[d]));
        chk($sformatf("%s done d%0d k%0d", tag, d, k), 32'(done_w[d]), 32'(k == ndig[d]));
        chk($sformatf("%s sum d%0d k%0d", tag, d, k), 32'(sum_w[d]),
            32'((k >= ndig[d]) ? es[d] : prev_sum[d]));
        chk($sformatf("%s cout d%0d k%0d", tag, d, k), 32'(cout_w[d]),
            32'((k >= ndig[d]) ? ec[d] : prev_cout[d]));
        chk($sformatf("%s ovf d%0d k%0d", tag, d, k), 32'(ovf_w[d]),
            32'((k >= ndig[d]) ? eo[d] : prev_ovf[d]));
      end
      if (k <= 1) begin
        start = protect;
        a     = protect ? 16'hAAAA : 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    for (int d = 0; d < 4; d++) begin
      prev_sum[d]  = es[d];
      prev_cout[d] = ec[d];
      prev_ovf[d]  = eo[d];
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      prev_sum[d] = '0; prev_cout[d] = 1'b0; prev_ovf[d] = 1'b0;
    end

    // Reset held with start asserted: nothing captured, outputs zero.
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero($sformatf("reset%0d", i));
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    run_add("basic",      16'h1234, 16'h4321, 1'b0, 1'b0);
    run_add("wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_add("signed_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run_add("protect",    16'h0F0F, 16'h00F1, 1'b0, 1'b1);

    // Reset after two RUN digits of the DIGIT=4 and DIGIT=1 configurations.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst busy d%0d", d), 32'(busy_w[d]), 32'd1);
      chk($sformatf("midrst done d%0d", d), 32'(done_w[d]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst_after");
    for (int d = 0; d < 4; d++) begin
      prev_sum[d] = '0; prev_cout[d] = 1'b0; prev_ovf[d] = 1'b0;
    end
    rst = 1'b0;
    run_add("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      run_add($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
